stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control sequencer for the two-digit BCD stopwatch counter. It conditions the raw start/stop and reset buttons and runs an IDLE/RUN/PAUSE/DONE state machine. It generates the prescaled count-enable tick and clear pulse that drive the counter, and reports run status to the display/LED logic.

Parameters:
DIV, 100000000, clock cycles per count tick (1 Hz at 100 MHz); minimum 2
DB_CYCLES, 1000000, consecutive stable samples required to accept a button level change; minimum 1
WRAP, 1, 1 = counter wraps 99->00 and keeps running; 0 = stop in DONE when the counter is at 99

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
btn_start_stop  input  1  raw start/stop button, asynchronous, active-high
btn_reset  input  1  raw reset button, asynchronous, active-high
count_max  input  1  from the counter: ones==9 && tens==9
tick_en  output  1  one-cycle count-enable pulse to the counter
clear  output  1  one-cycle synchronous clear pulse to the counter
running  output  1  high in RUN
paused  output  1  high in PAUSE
state  output  2  encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Reset (rst=0): state=IDLE, tick_en=0, clear=0, running=0, paused=0, prescaler=0. Synchronizers, debounce counters and debounced levels are all 0. Reset is asserted asynchronously and released on the clock.
- All outputs are registered. running, paused and state are decoded from the state register.
- Button path, per button:
  - 2-FF synchronizer.
  - Debounce counter: resets whenever the synchronized sample equals the debounced level. The debounced level flips after DB_CYCLES consecutive differing samples.
  - A press is a 1-cycle pulse on the debounced rising edge. Releases generate nothing.
  - Latency from a clean raw edge to the press pulse: 2 + DB_CYCLES cycles (±1).
- Priority: a reset press beats a start_stop press in the same cycle.
- Transitions:
  - any state + reset press -> IDLE. clear=1 for exactly one cycle, prescaler=0. Reset pressed while already in IDLE still pulses clear.
  - IDLE + start press -> RUN, prescaler=0.
  - RUN + start press -> PAUSE. Prescaler frozen at its current value.
  - PAUSE + start press -> RUN. Prescaler resumes from the frozen value, so there is no partial-second loss.
  - RUN, prescaler==DIV-1:
    - if WRAP=0 and count_max=1: go to DONE, no tick_en.
    - otherwise: tick_en=1 for one cycle.
    - In both cases the prescaler returns to 0.
  - DONE: start presses ignored; only a reset press exits.
- tick_en appears only in RUN, exactly once per DIV RUN cycles. The first tick comes DIV cycles after entering RUN from IDLE.
- A start press on the same cycle the prescaler hits DIV-1 in RUN: the tick is still issued, and the state moves to PAUSE.
- tick_en and clear are never high in the same cycle.
- Prescaler width: $clog2(DIV). Debounce counter width: $clog2(DB_CYCLES+1). Neither may overflow.

Optional Feature:
LAP_HOLD_EN
- Defined:
  - Adds input btn_lap (raw, conditioned like the other buttons) and output lap_hold.
  - In RUN or PAUSE, a lap press toggles lap_hold. The display freezes while the counter and tick_en continue.
  - lap_hold is forced to 0 on entry to IDLE or DONE. Lap presses in IDLE or DONE are ignored.
  - Reset value of lap_hold is 0.
- Undefined: btn_lap and lap_hold do not exist; no lap logic.

Decomposition:
- Package stopwatch_pkg holds:
  - the state typedef (IDLE/RUN/PAUSE/DONE, 2-bit);
  - default DIV and DB_CYCLES constants;
  - the BCD_MAX=9 constant shared with the counter.
- One sub-module, btn_cond: synchronizer, debouncer and rising-edge pulse. It is parameterized by DB_CYCLES and instantiated once per button.

Test Plan:
Simulation parameters: DIV=10, DB_CYCLES=4.
1. Hold rst=0 for 3 cycles, release, no buttons -> state=0; tick_en, clear, running, paused all 0 for 50 cycles.
2. Press start (held 10 cycles) -> state=1 about 6 cycles after the edge. tick_en pulses every 10 cycles, the first 10 cycles after entering RUN. 5 ticks counted in 50 cycles.
3. RUN; press start 3 cycles after a tick -> PAUSE with no tick for 40 cycles. Press start again -> RUN, and the next tick arrives 7 cycles after re-entry.
4. RUN; press reset and start on the same cycle -> state=0, one-cycle clear=1, no further tick_en.
5. WRAP=0, count_max=1, RUN -> at the prescaler wrap, state=3 and no tick_en. A start press stays in DONE. A reset press gives IDLE plus clear.
6. Button bounce: toggle btn_start_stop every 2 cycles for 20 cycles, then hold high -> exactly one press and a single IDLE->RUN transition.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path.
package stopwatch_pkg;

    // Sequencer states; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // 1 Hz tick from a 100 MHz clock.
    localparam int DIV_DEFAULT = 100_000_000;

    // Roughly 10 ms of stable level at 100 MHz before a button change is accepted.
    localparam int DB_CYCLES_DEFAULT = 1_000_000;

    // Largest value of a BCD digit; the counter's count_max is ones==tens==BCD_MAX.
    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_btn_cond.sv
// Button conditioner: 2-FF synchronizer, debouncer and a one-cycle press
// pulse on the debounced rising edge. Releases produce no pulse.
module btn_cond
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Bring the raw asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], btn};
        end
    end

    // Count consecutive samples that differ from the accepted level; the
    // level flips on the DB_CYCLES-th one and a rising flip emits a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
                press <= sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: conditions the start/stop and reset buttons,
// runs the IDLE/RUN/PAUSE/DONE machine, and produces the prescaled count
// tick and clear pulse for the two-digit BCD counter.
// Optional lap-hold display freeze is built when LAP_HOLD_EN is defined.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | counter cleared, waiting for a start press
// RUN    | prescaler advancing, tick_en once every DIV cycles
// PAUSE  | prescaler frozen, resumes where it stopped
// DONE   | counter held at 99 (WRAP=0 only); only reset exits
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIV       = DIV_DEFAULT,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter bit WRAP      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_reset,
    input  logic       count_max,
    output logic       tick_en,
    output logic       clear,
    output logic       running,
    output logic       paused,
    output logic [1:0] state
`ifdef LAP_HOLD_EN
    ,
    input  logic       btn_lap,
    output logic       lap_hold
`endif
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [1:0]    rst_sync;
    logic          rst_int;
    logic          press_start;
    logic          press_reset;
    logic [PW-1:0] presc;
    state_t        state_q;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int = rst_sync[1];

    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_start (
        .clk   (clk),
        .rst   (rst_int),
        .btn   (btn_start_stop),
        .press (press_start)
    );

    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_reset (
        .clk   (clk),
        .rst   (rst_int),
        .btn   (btn_reset),
        .press (press_reset)
    );

    // Sequencer with registered tick/clear/status outputs; reset press wins.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state_q <= S_IDLE;
            presc   <= '0;
            tick_en <= 1'b0;
            clear   <= 1'b0;
            running <= 1'b0;
            paused  <= 1'b0;
        end else begin
            tick_en <= 1'b0;
            clear   <= 1'b0;
            if (press_reset) begin
                state_q <= S_IDLE;
                presc   <= '0;
                clear   <= 1'b1;
                running <= 1'b0;
                paused  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (press_start) begin
                            state_q <= S_RUN;
                            presc   <= '0;
                            running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (presc == PRESC_LAST) begin
                            // A second boundary always completes, even with a
                            // start press pending on the same cycle.
                            presc <= '0;
                            if (!WRAP && count_max) begin
                                state_q <= S_DONE;
                                running <= 1'b0;
                            end else begin
                                tick_en <= 1'b1;
                                if (press_start) begin
                                    state_q <= S_PAUSE;
                                    running <= 1'b0;
                                    paused  <= 1'b1;
                                end
                            end
                        end else if (press_start) begin
                            state_q <= S_PAUSE;
                            running <= 1'b0;
                            paused  <= 1'b1;
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    S_PAUSE: begin
                        if (press_start) begin
                            state_q <= S_RUN;
                            running <= 1'b1;
                            paused  <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_DONE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        running <= 1'b0;
                        paused  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = state_q;

`ifdef LAP_HOLD_EN
    logic press_lap;

    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_lap (
        .clk   (clk),
        .rst   (rst_int),
        .btn   (btn_lap),
        .press (press_lap)
    );

    // Lap hold toggles only while timing; cleared whenever IDLE or DONE is entered.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            lap_hold <= 1'b0;
        end else if (press_reset) begin
            lap_hold <= 1'b0;
        end else if (state_q == S_RUN && presc == PRESC_LAST && !WRAP && count_max) begin
            lap_hold <= 1'b0;
        end else if (press_lap && (state_q == S_RUN || state_q == S_PAUSE)) begin
            lap_hold <= ~lap_hold;
        end
    end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DIV=10, DB_CYCLES=4. dut_w wraps (WRAP=1)
// and is checked cycle by cycle against a run-time model; dut_d (WRAP=0)
// covers the DONE path using a small BCD counter model to drive count_max.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int DIV = 10;
    localparam int DB  = 4;
    // Raw button edge driven after edge N is acted on by the sequencer at edge N+LAT.
    localparam int LAT = DB + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ss1 = 1'b0, rs1 = 1'b0, cm1 = 1'b0;
    logic       tick1, clr1, run1, pau1;
    logic [1:0] st1;
    logic       ss2 = 1'b0, rs2 = 1'b0, cm2;
    logic       tick2, clr2, run2, pau2;
    logic [1:0] st2;
    logic [3:0] ones, tens;
`ifdef LAP_HOLD_EN
    logic       lap1 = 1'b0, lap2 = 1'b0;
    logic       lh1, lh2;
`endif

    stopwatch_ctrl #(.DIV(DIV), .DB_CYCLES(DB), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .btn_start_stop(ss1), .btn_reset(rs1),
        .count_max(cm1), .tick_en(tick1), .clear(clr1), .running(run1),
        .paused(pau1), .state(st1)
`ifdef LAP_HOLD_EN
        , .btn_lap(lap1), .lap_hold(lh1)
`endif
    );

    stopwatch_ctrl #(.DIV(DIV), .DB_CYCLES(DB), .WRAP(1'b0)) dut_d (
        .clk(clk), .rst(rst), .btn_start_stop(ss2), .btn_reset(rs2),
        .count_max(cm2), .tick_en(tick2), .clear(clr2), .running(run2),
        .paused(pau2), .state(st2)
`ifdef LAP_HOLD_EN
        , .btn_lap(lap2), .lap_hold(lh2)
`endif
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    // Two-digit BCD counter fed by dut_d, preset to 98.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones <= 4'd8;
            tens <= 4'd9;
        end else if (tick2) begin
            if (ones == BCD_MAX) begin
                ones <= 4'd0;
                tens <= (tens == BCD_MAX) ? 4'd0 : tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end
    assign cm2 = (ones == BCD_MAX) && (tens == BCD_MAX);

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model for dut_w: mode plus total elapsed run time.
    int m_state;
    int m_elapsed;
    bit m_tick, m_clear;
    int ev_ss = -1, ev_rs = -1, rel_ss = -1, rel_rs = -1;

    function void model_edge(bit st, bit rs);
        m_tick  = 0;
        m_clear = 0;
        if (rs) begin
            m_state   = 0;
            m_elapsed = 0;
            m_clear   = 1;
        end else if (m_state == 0) begin
            if (st) begin
                m_state   = 1;
                m_elapsed = 0;
            end
        end else if (m_state == 1) begin
            if ((m_elapsed % DIV) == DIV - 1) begin
                m_tick = 1;
                m_elapsed++;
                if (st) m_state = 2;
            end else if (st) begin
                m_state = 2;
            end else begin
                m_elapsed++;
            end
        end else if (m_state == 2) begin
            if (st) m_state = 1;
        end
    endfunction

    function logic [5:0] model_vec();
        return {2'(m_state), m_tick, m_clear, (m_state == 1), (m_state == 2)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge(edge_n == ev_ss, edge_n == ev_rs);
        if (edge_n == rel_ss) ss1 = 1'b0;
        if (edge_n == rel_rs) rs1 = 1'b0;
    endtask

    task automatic press1(bit s, bit r);
        if (s) begin
            ss1 = 1'b1; ev_ss = edge_n + LAT; rel_ss = edge_n + 10;
        end
        if (r) begin
            rs1 = 1'b1; ev_rs = edge_n + LAT; rel_rs = edge_n + 10;
        end
    endtask

    task automatic hw_reset();
        rst = 1'b0;
        ss1 = 1'b0; rs1 = 1'b0; cm1 = 1'b0; ss2 = 1'b0; rs2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        m_state = 0; m_elapsed = 0; m_tick = 0; m_clear = 0;
        ev_ss = -1; ev_rs = -1; rel_ss = -1; rel_rs = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({st1, tick1, clr1, run1, pau1, st2, tick2, clr2, run2, pau2} !== 12'd0) begin
                n_fail++;
                $display("FAIL reset_hold: got %b %b required all zero",
                         {st1, tick1, clr1, run1, pau1}, {st2, tick2, clr2, run2, pau2});
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({st1, tick1, clr1, run1, pau1, st2, tick2, clr2, run2, pau2} !== 12'd0) begin
                n_fail++;
                $display("FAIL reset_idle: cycle %0d got %b %b required all zero", i,
                         {st1, tick1, clr1, run1, pau1}, {st2, tick2, clr2, run2, pau2});
            end
        end
        m_state = 0; m_elapsed = 0; m_tick = 0; m_clear = 0;
    endtask

    task automatic test_start();
        int n0, ticks;
        hw_reset();
        n0 = edge_n;
        ticks = 0;
        press1(1, 0);
        for (int i = 0; i < 57; i++) begin
            cycle();
            if (tick1) ticks++;
            n_checks++;
            if ({st1, tick1, clr1, run1, pau1} !== model_vec()) begin
                n_fail++;
                $display("FAIL start: edge %0d got %b required %b", edge_n - n0,
                         {st1, tick1, clr1, run1, pau1}, model_vec());
            end
        end
        n_checks++;
        if (ticks !== 5) begin
            n_fail++;
            $display("FAIL start_tick_count: got %0d required 5", ticks);
        end
    endtask

    task automatic test_pause();
        int n0, t_res;
        hw_reset();
        n0 = edge_n;
        t_res = -1;
        press1(1, 0);
        for (int i = 0; i < 100; i++) begin
            if (edge_n == n0 + 24 || edge_n == n0 + 64) press1(1, 0);
            cycle();
            if (tick1 && edge_n > n0 + 71 && t_res < 0) t_res = edge_n;
            n_checks++;
            if ({st1, tick1, clr1, run1, pau1} !== model_vec()) begin
                n_fail++;
                $display("FAIL pause: edge %0d got %b required %b", edge_n - n0,
                         {st1, tick1, clr1, run1, pau1}, model_vec());
            end
        end
        n_checks++;
        if (t_res - (n0 + 71) !== DIV - 3) begin
            n_fail++;
            $display("FAIL resume_gap: got %0d required %0d", t_res - (n0 + 71), DIV - 3);
        end
    endtask

    task automatic test_press_at_wrap();
        int n0;
        hw_reset();
        n0 = edge_n;
        press1(1, 0);
        for (int i = 0; i < 50; i++) begin
            if (edge_n == n0 + 20) press1(1, 0);
            cycle();
            n_checks++;
            if ({st1, tick1, clr1, run1, pau1} !== model_vec()) begin
                n_fail++;
                $display("FAIL press_at_wrap: edge %0d got %b required %b", edge_n - n0,
                         {st1, tick1, clr1, run1, pau1}, model_vec());
            end
            if (edge_n == n0 + 27) begin
                n_checks++;
                if ({tick1, st1} !== 3'b1_10) begin
                    n_fail++;
                    $display("FAIL wrap_tick_and_pause: got tick=%b state=%0d required tick=1 state=2",
                             tick1, st1);
                end
            end
        end
    endtask

    task automatic test_reset_priority();
        int n0, clears, late_ticks;
        hw_reset();
        n0 = edge_n;
        clears = 0;
        late_ticks = 0;
        press1(1, 0);
        for (int i = 0; i < 75; i++) begin
            if (edge_n == n0 + 25) press1(1, 1);
            if (edge_n == n0 + 50) press1(0, 1);
            cycle();
            if (clr1) clears++;
            if (tick1 && edge_n > n0 + 32) late_ticks++;
            n_checks++;
            if ({st1, tick1, clr1, run1, pau1} !== model_vec()) begin
                n_fail++;
                $display("FAIL reset_priority: edge %0d got %b required %b", edge_n - n0,
                         {st1, tick1, clr1, run1, pau1}, model_vec());
            end
        end
        n_checks++;
        if (clears !== 2 || late_ticks !== 0) begin
            n_fail++;
            $display("FAIL clear_pulses: got clears=%0d ticks=%0d required clears=2 ticks=0",
                     clears, late_ticks);
        end
    endtask

    task automatic test_bounce();
        int n0, entries;
        logic [1:0] prev;
        hw_reset();
        n0 = edge_n;
        entries = 0;
        prev = st1;
        for (int i = 0; i < 60; i++) begin
            if (i < 20 && (i % 2) == 0) ss1 = ((i / 2) % 2 == 0);
            if (i == 20) begin
                ss1 = 1'b1; ev_ss = edge_n + LAT; rel_ss = edge_n + 12;
            end
            cycle();
            if (prev == 2'd0 && st1 == 2'd1) entries++;
            prev = st1;
            n_checks++;
            if ({st1, tick1, clr1, run1, pau1} !== model_vec()) begin
                n_fail++;
                $display("FAIL bounce: edge %0d got %b required %b", edge_n - n0,
                         {st1, tick1, clr1, run1, pau1}, model_vec());
            end
        end
        n_checks++;
        if (entries !== 1) begin
            n_fail++;
            $display("FAIL bounce_entries: got %0d required 1", entries);
        end
    endtask

    task automatic test_random();
        int next_drive;
        bit r, s;
        hw_reset();
        next_drive = edge_n + 2;
        for (int i = 0; i < 700; i++) begin
            cm1 = 1'($urandom);
            if (edge_n == next_drive) begin
                r = ($urandom_range(0, 4) == 0);
                s = r ? 1'($urandom) : 1'b1;
                press1(s, r);
                next_drive = edge_n + $urandom_range(20, 45);
            end
            cycle();
            n_checks++;
            if ({st1, tick1, clr1, run1, pau1} !== model_vec()) begin
                n_fail++;
                $display("FAIL random: edge %0d got %b required %b", edge_n,
                         {st1, tick1, clr1, run1, pau1}, model_vec());
            end
        end
    endtask

    task automatic test_done();
        int n0, e;
        logic [1:0] x_st;
        hw_reset();
        n0 = edge_n;
        for (int i = 0; i < 80; i++) begin
            if (i == 0 || i == 40) ss2 = 1'b1;
            if (i == 10 || i == 50) ss2 = 1'b0;
            if (i == 60) rs2 = 1'b1;
            if (i == 70) rs2 = 1'b0;
            @(posedge clk);
            #1;
            e = edge_n - n0;
            x_st = (e < 7) ? 2'd0 : (e < 27) ? 2'd1 : (e < 67) ? 2'd3 : 2'd0;
            n_checks++;
            if ({st2, tick2, clr2, run2, pau2} !== {x_st, (e == 17), (e == 67), (x_st == 2'd1), 1'b0}) begin
                n_fail++;
                $display("FAIL done: edge %0d got %b required %b", e,
                         {st2, tick2, clr2, run2, pau2},
                         {x_st, (e == 17), (e == 67), (x_st == 2'd1), 1'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause();
        test_press_at_wrap();
        test_reset_priority();
        test_bounce();
        test_random();
        test_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
